// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl opcodes and the multiply sequencer state enum.
// Used by the multiply sequencer, the ALU and the ALU control unit.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADD,
    DONE
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/control bus between an ALU initiator (master) and the combinational ALU (slave).
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned CTRL_W = 4
);

  logic [CTRL_W-1:0] ALUCtrl;
  logic [WIDTH-1:0]  BusA;
  logic [WIDTH-1:0]  BusB;
  logic [WIDTH-1:0]  BusW;
  logic              Zero;

  modport master (
    output ALUCtrl,
    output BusA,
    output BusB,
    input  BusW,
    input  Zero
  );

  modport slave (
    input  ALUCtrl,
    input  BusA,
    input  BusB,
    output BusW,
    output Zero
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Iterative unsigned shift-and-add multiplier that borrows the external ALU for every
// add and for the "multiplier exhausted" test (PassB + Zero flag).
// Optional build macro MUL_OVF_EN adds a sticky Overflow output.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned CTRL_W = 4
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] MulA,
  input  logic [WIDTH-1:0] MulB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
`ifdef MUL_OVF_EN
  output logic             Overflow,
`endif
  alu_mul_sequencer_if.master alu
);

  mul_state_e r_state, w_state_next;
  logic [WIDTH-1:0] r_acc, w_acc_next;
  logic [WIDTH-1:0] r_mcand, w_mcand_next;
  logic [WIDTH-1:0] r_mplier, w_mplier_next;
  logic [WIDTH-1:0] r_product, w_product_next;

`ifdef MUL_OVF_EN
  logic r_ovf, w_ovf_next;
  logic w_shift_lost;

  // A shift drops a set bit that still has multiplier bits left to weight it.
  assign w_shift_lost = r_mcand[WIDTH-1] && ((r_mplier >> 1) != '0);
  assign Overflow     = r_ovf;
`endif

  // Product is visible in DONE directly from the accumulator.
  assign Product = (r_state == DONE) ? r_acc : r_product;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
`ifdef MUL_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_mcand   <= w_mcand_next;
      r_mplier  <= w_mplier_next;
      r_product <= w_product_next;
`ifdef MUL_OVF_EN
      r_ovf     <= w_ovf_next;
`endif
    end
  end

  // Next-state, datapath updates and ALU/handshake outputs.
  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_mcand_next   = r_mcand;
    w_mplier_next  = r_mplier;
    w_product_next = r_product;
`ifdef MUL_OVF_EN
    w_ovf_next     = r_ovf;
`endif
    alu.ALUCtrl    = CTRL_W'(ALU_AND);
    alu.BusA       = '0;
    alu.BusB       = '0;
    Busy           = 1'b0;
    Done           = 1'b0;

    case (r_state)
      IDLE: begin
        if (Start) begin
          w_mcand_next  = MulA;
          w_mplier_next = MulB;
          w_acc_next    = '0;
`ifdef MUL_OVF_EN
          w_ovf_next    = 1'b0;
`endif
          w_state_next  = CHECK;
        end
      end

      CHECK: begin
        Busy        = 1'b1;
        alu.ALUCtrl = CTRL_W'(ALU_PASSB);
        alu.BusB    = r_mplier;
        if (alu.Zero) begin
          w_state_next = DONE;
        end else if (r_mplier[0]) begin
          w_state_next = ADD;
        end else begin
          w_mcand_next  = r_mcand << 1;
          w_mplier_next = r_mplier >> 1;
`ifdef MUL_OVF_EN
          if (w_shift_lost) w_ovf_next = 1'b1;
`endif
        end
      end

      ADD: begin
        Busy          = 1'b1;
        alu.ALUCtrl   = CTRL_W'(ALU_ADD);
        alu.BusA      = r_acc;
        alu.BusB      = r_mcand;
        w_acc_next    = alu.BusW;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
`ifdef MUL_OVF_EN
        // Unsigned carry-out shows up as a wrapped sum smaller than an operand.
        if ((alu.BusW < r_acc) || w_shift_lost) w_ovf_next = 1'b1;
`endif
        w_state_next  = CHECK;
      end

      DONE: begin
        Done           = 1'b1;
        w_product_next = r_acc;
        w_state_next   = IDLE;
      end

      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural combinational ALU on the bus.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CTRL_W = 4;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic [WIDTH-1:0] MulA;
  logic [WIDTH-1:0] MulB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Product;
  logic             Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ctrl_seq[$];

  alu_mul_sequencer_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) alu_bus ();

  alu_mul_sequencer #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .MulA     (MulA),
    .MulB     (MulB),
    .Busy     (Busy),
    .Done     (Done),
    .Product  (Product),
`ifdef MUL_OVF_EN
    .Overflow (Overflow),
`endif
    .alu      (alu_bus)
  );

`ifndef MUL_OVF_EN
  assign Overflow = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Behavioural ALU
  always_comb begin
    alu_bus.BusW = '0;
    case (alu_bus.ALUCtrl)
      ALU_AND:   alu_bus.BusW = alu_bus.BusA & alu_bus.BusB;
      ALU_OR:    alu_bus.BusW = alu_bus.BusA | alu_bus.BusB;
      ALU_ADD:   alu_bus.BusW = alu_bus.BusA + alu_bus.BusB;
      ALU_SUB:   alu_bus.BusW = alu_bus.BusA - alu_bus.BusB;
      ALU_PASSB: alu_bus.BusW = alu_bus.BusB;
      default:   alu_bus.BusW = '0;
    endcase
    alu_bus.Zero = (alu_bus.BusW == '0);
  end

  // Starts an operation (accept edge = edge 0) and runs until Done or a 200-cycle budget.
  // restart_c > 0 pulses a second Start during that cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int restart_c, output int done_c, output int busy_first,
                        output int busy_last, output int busy_n,
                        output logic [WIDTH-1:0] prod_d, output logic ovf_d);
    ctrl_seq.delete();
    done_c = 0; busy_first = 0; busy_last = 0; busy_n = 0; prod_d = '0; ovf_d = 1'b0;
    @(negedge CLK);
    MulA = a; MulB = b; Start = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 200 && done_c == 0; c++) begin
      @(negedge CLK);
      Start = (c == restart_c);
      if (c == restart_c) begin
        MulA = 64'd9;
        MulB = 64'd9;
      end
      if (Busy) begin
        ctrl_seq.push_back(alu_bus.ALUCtrl);
        if (busy_first == 0) busy_first = c;
        busy_last = c;
        busy_n++;
      end
      if (Done) begin
        done_c = c;
        prod_d = Product;
        ovf_d  = Overflow;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
    n_tests++;
    if (Product !== '0) begin
      n_fail++; $display("FAIL reset_product: got %h want 0", Product);
    end
    n_tests++;
    if (alu_bus.ALUCtrl !== 4'b0000 || alu_bus.BusA !== '0 || alu_bus.BusB !== '0) begin
      n_fail++;
      $display("FAIL reset_alu: ctrl=%b A=%h B=%h want 0000 0 0", alu_bus.ALUCtrl,
               alu_bus.BusA, alu_bus.BusB);
    end
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int d, bf, bl, bn;
    logic [WIDTH-1:0] p;
    logic o;
    logic [23:0] seq;
    run_op(64'd3, 64'd5, 0, d, bf, bl, bn, p, o);
    seq = '0;
    foreach (ctrl_seq[i]) seq = {seq[19:0], ctrl_seq[i]};
    n_tests++;
    if (d !== 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 7", d); end
    n_tests++;
    if (p !== 64'd15) begin n_fail++; $display("FAIL basic_product: got %0d want 15", p); end
    n_tests++;
    if (ctrl_seq.size() != 6 || seq !== 24'h727727) begin
      n_fail++;
      $display("FAIL basic_ctrl_seq: got n=%0d seq=%h want n=6 seq=727727", ctrl_seq.size(), seq);
    end
    n_tests++;
    if (bf != 1 || bl != 6) begin
      n_fail++; $display("FAIL basic_busy_window: got %0d..%0d want 1..6", bf, bl);
    end
`ifdef MUL_OVF_EN
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", o); end
`endif
    @(negedge CLK);
    n_tests++;
    if (Done !== 1'b0 || Product !== 64'd15 || alu_bus.ALUCtrl !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_after: Done=%b Product=%0d ctrl=%b want 0 15 0000", Done, Product,
               alu_bus.ALUCtrl);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    @(negedge CLK);
    MulA = 64'd3; MulB = 64'd5; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (alu_bus.ALUCtrl !== ALU_ADD) begin
      n_fail++; $display("FAIL rstmid_in_add: ctrl=%b want 0010", alu_bus.ALUCtrl);
    end
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== '0 || alu_bus.ALUCtrl !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: Busy=%b Done=%b Product=%h ctrl=%b want 0 0 0 0000",
               Busy, Done, Product, alu_bus.ALUCtrl);
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (Done || Busy) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL rstmid_no_done: active cycles=%0d want 0", seen_done);
    end
  endtask

  task automatic test_zero_mulb();
    int d, bf, bl, bn;
    logic [WIDTH-1:0] p;
    logic o;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, d, bf, bl, bn, p, o);
    n_tests++;
    if (d !== 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 2", d); end
    n_tests++;
    if (p !== '0) begin n_fail++; $display("FAIL zero_product: got %h want 0", p); end
    n_tests++;
    if (ctrl_seq.size() != 1 || ctrl_seq[0] !== ALU_PASSB) begin
      n_fail++; $display("FAIL zero_passb_count: got n=%0d want 1 PassB", ctrl_seq.size());
    end
  endtask

  task automatic test_wrap();
    int d, bf, bl, bn;
    logic [WIDTH-1:0] p;
    logic o;
    run_op(64'h1_0000_0000, 64'h1_0000_0000, 0, d, bf, bl, bn, p, o);
    n_tests++;
    if (d !== 36) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 36", d); end
    n_tests++;
    if (p !== '0) begin n_fail++; $display("FAIL wrap_product: got %h want 0", p); end
`ifdef MUL_OVF_EN
    n_tests++;
    if (o !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", o); end
`endif
  endtask

  task automatic test_ignore_start();
    int d, bf, bl, bn, bad;
    logic [WIDTH-1:0] p;
    logic o;
    run_op(64'd7, 64'd6, 3, d, bf, bl, bn, p, o);
    n_tests++;
    if (d !== 7) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 7", d); end
    n_tests++;
    if (p !== 64'd42) begin n_fail++; $display("FAIL ignore_product: got %0d want 42", p); end
`ifdef MUL_OVF_EN
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL ignore_ovf: got %b want 0", o); end
`endif
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (Busy || Done || Product !== 64'd42) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ignore_hold: bad cycles=%0d Product=%0d want 0 and 42", bad, Product);
    end
  endtask

  task automatic test_long();
    int d, bf, bl, bn;
    logic [WIDTH-1:0] p;
    logic o;
    run_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, bf, bl, bn, p, o);
    n_tests++;
    if (d !== 130) begin n_fail++; $display("FAIL long_done_cycle: got %0d want 130", d); end
    n_tests++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL long_product: got %h want fffffffffffffffe", p);
    end
    n_tests++;
    if (bf != 1 || bl != 129 || bn != 129) begin
      n_fail++; $display("FAIL long_busy: got %0d..%0d n=%0d want 1..129 n=129", bf, bl, bn);
    end
`ifdef MUL_OVF_EN
    n_tests++;
    if (o !== 1'b1) begin n_fail++; $display("FAIL long_ovf: got %b want 1", o); end
`endif
  endtask

  initial begin
    Reset_n = 1'b0;
    Start   = 1'b0;
    MulA    = '0;
    MulB    = '0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_zero_mulb();
    test_wrap();
    test_ignore_start();
    test_long();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
